// File: rtl/tea_pkg.sv
// tea_pkg: shared definitions for the 16-bit-half TEA-style cipher blocks.
//   TEA_ROUNDS      number of rounds per 32-bit word
//   HW              half-word width
//   OFF_*           APB-lite register byte offsets
//   reg_sel_e       decoded register select
//   reg_decode()    byte address -> register select
//   tea_f()         round mixing function F(v,sum,ka,kb)
package tea_pkg;

   localparam int unsigned TEA_ROUNDS = 16;
   localparam int unsigned HW         = 16;

   localparam logic [31:0] OFF_KEY10  = 32'h0000_0000;
   localparam logic [31:0] OFF_KEY32  = 32'h0000_0004;
   localparam logic [31:0] OFF_DELTA  = 32'h0000_0008;
   localparam logic [31:0] OFF_IV     = 32'h0000_000C;
   localparam logic [31:0] OFF_STATUS = 32'h0000_0010;

   typedef enum logic [2:0] {
      REG_KEY10,
      REG_KEY32,
      REG_DELTA,
      REG_IV,
      REG_STATUS,
      REG_NONE
   } reg_sel_e;

   function automatic reg_sel_e reg_decode(input logic [31:0] addr);
      reg_sel_e sel;
      case (addr)
         OFF_KEY10:  sel = REG_KEY10;
         OFF_KEY32:  sel = REG_KEY32;
         OFF_DELTA:  sel = REG_DELTA;
         OFF_IV:     sel = REG_IV;
         OFF_STATUS: sel = REG_STATUS;
         default:    sel = REG_NONE;
      endcase
      return sel;
   endfunction

   // Shifts are logical and truncated to HW bits; all adds wrap mod 2^HW.
   function automatic logic [HW-1:0] tea_f(input logic [HW-1:0] v,
                                           input logic [HW-1:0] sum,
                                           input logic [HW-1:0] ka,
                                           input logic [HW-1:0] kb);
      logic [HW-1:0] vs;
      vs = v << 4;
      return (vs + ka) ^ (v + sum) ^ ((v >> 5) + kb);
   endfunction

endpackage

// File: rtl/tea_round_dec.sv
// tea_round_dec: one combinational inverse round of the TEA-style cipher.
//   x_i, y_i      current halves
//   sum_i         current round sum
//   k0_i..k3_i    key words
//   x_o, y_o      halves after the inverse round (y is undone first, x uses new y)
module tea_round_dec
   import tea_pkg::*;
(
   input  logic [HW-1:0] x_i,
   input  logic [HW-1:0] y_i,
   input  logic [HW-1:0] sum_i,
   input  logic [HW-1:0] k0_i,
   input  logic [HW-1:0] k1_i,
   input  logic [HW-1:0] k2_i,
   input  logic [HW-1:0] k3_i,
   output logic [HW-1:0] x_o,
   output logic [HW-1:0] y_o
);

   assign y_o = y_i - tea_f(x_i, sum_i, k2_i, k3_i);
   assign x_o = x_i - tea_f(y_o, sum_i, k0_i, k1_i);

endmodule

// File: rtl/tinydec.sv
// tinydec: TEA-style block decryptor, 32-bit word {y,x}, 16 rounds, one round per clk.
//   clk, prstb            clock, async active-low reset (released synchronously)
//   req, wdata, ack       start handshake / ciphertext in / idle-result-valid
//   rdata                 plaintext {y,x}, held until the next completion
//   psel, penable, pwrite, paddr, pwdata, prdata, pready   APB-lite key/delta/iv/status
// Optional macro TINYDEC_CBC_EN adds a 32-bit iv register for CBC chaining;
// without it the block is ECB only and the iv offset reads 0.
module tinydec
   import tea_pkg::*;
#(
   parameter logic [63:0] KEY   = 64'h816fc52b09e74da3,
   parameter logic [15:0] DELTA = 16'h9E37
) (
   input  logic        clk,
   input  logic        prstb,
   output logic        ack,
   output logic [31:0] rdata,
   input  logic [31:0] wdata,
   input  logic        req,
   output logic        pready,
   output logic [31:0] prdata,
   input  logic [31:0] pwdata,
   input  logic        pwrite,
   input  logic [31:0] paddr,
   input  logic        psel,
   input  logic        penable
);

   logic            rst_sync_q;
   logic            rst_n;

   logic [4:0]      i_q, i_d;
   logic [HW-1:0]   x_q, x_d, y_q, y_d, sum_q, sum_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [31:0]     prdata_q, prdata_d;
   logic [63:0]     k_q, k_d;
   logic [HW-1:0]   delta_q, delta_d;
   logic [1:0]      psel_d_q, psel_d_d;
   logic [31:0]     iv_val;
`ifdef TINYDEC_CBC_EN
   logic [31:0]     iv_q, iv_d, c_q, c_d;
`endif

   logic [HW-1:0]   x_rnd, y_rnd;
   logic            ack_w, frozen, wr_en;
   reg_sel_e        sel;
   logic [31:0]     rd_val;

   // Reset asserts immediately and is released on the next clk edge.
   always_ff @(posedge clk or negedge prstb) begin
      if (!prstb) rst_sync_q <= 1'b0;
      else        rst_sync_q <= 1'b1;
   end
   assign rst_n = rst_sync_q;

   tea_round_dec u_round (
      .x_i   (x_q),
      .y_i   (y_q),
      .sum_i (sum_q),
      .k0_i  (k_q[15:0]),
      .k1_i  (k_q[31:16]),
      .k2_i  (k_q[47:32]),
      .k3_i  (k_q[63:48]),
      .x_o   (x_rnd),
      .y_o   (y_rnd)
   );

   assign ack_w  = (i_q == '0);
   assign frozen = psel_d_q[1];
   assign wr_en  = psel & penable & pwrite;
   assign sel    = reg_decode(paddr);

`ifdef TINYDEC_CBC_EN
   assign iv_val = iv_q;
`else
   assign iv_val = '0;
`endif

   always_comb begin
      rd_val = '0;
      case (sel)
         REG_KEY10:  rd_val = k_q[31:0];
         REG_KEY32:  rd_val = k_q[63:32];
         REG_DELTA:  rd_val = {16'h0, delta_q};
         REG_IV:     rd_val = iv_val;
         REG_STATUS: rd_val = {31'h0, ~ack_w};
         default:    rd_val = '0;
      endcase
   end

   always_comb begin
      i_d      = i_q;
      x_d      = x_q;
      y_d      = y_q;
      sum_d    = sum_q;
      rdata_d  = rdata_q;
      prdata_d = prdata_q;
      k_d      = k_q;
      delta_d  = delta_q;
      psel_d_d = {psel_d_q[0], psel};
`ifdef TINYDEC_CBC_EN
      iv_d     = iv_q;
      c_d      = c_q;
`endif

      if (!frozen) begin
         if (ack_w) begin
            if (req) begin
               i_d   = 5'(TEA_ROUNDS);
               x_d   = wdata[15:0];
               y_d   = wdata[31:16];
               sum_d = {delta_q[11:0], 4'h0};
`ifdef TINYDEC_CBC_EN
               c_d   = wdata;
`endif
            end
         end else begin
            x_d   = x_rnd;
            y_d   = y_rnd;
            sum_d = sum_q - delta_q;
            i_d   = i_q - 5'd1;
            if (i_q == 5'd1) begin
`ifdef TINYDEC_CBC_EN
               rdata_d = {y_rnd, x_rnd} ^ iv_q;
               iv_d    = c_q;
`else
               rdata_d = {y_rnd, x_rnd};
`endif
            end
         end
      end

      if (psel) prdata_d = rd_val;

      // A software iv write in the same cycle as a completion takes priority.
      if (wr_en) begin
         case (sel)
            REG_KEY10: k_d[31:0]  = pwdata;
            REG_KEY32: k_d[63:32] = pwdata;
            REG_DELTA: delta_d    = pwdata[15:0];
`ifdef TINYDEC_CBC_EN
            REG_IV:    iv_d       = pwdata;
`endif
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_q      <= '0;
         x_q      <= '0;
         y_q      <= '0;
         sum_q    <= '0;
         rdata_q  <= '0;
         prdata_q <= '0;
         k_q      <= KEY;
         delta_q  <= DELTA;
         psel_d_q <= '0;
`ifdef TINYDEC_CBC_EN
         iv_q     <= '0;
         c_q      <= '0;
`endif
      end else begin
         i_q      <= i_d;
         x_q      <= x_d;
         y_q      <= y_d;
         sum_q    <= sum_d;
         rdata_q  <= rdata_d;
         prdata_q <= prdata_d;
         k_q      <= k_d;
         delta_q  <= delta_d;
         psel_d_q <= psel_d_d;
`ifdef TINYDEC_CBC_EN
         iv_q     <= iv_d;
         c_q      <= c_d;
`endif
      end
   end

   assign ack    = ack_w;
   assign rdata  = rdata_q;
   assign prdata = prdata_q;
   assign pready = 1'b1;

endmodule

// File: tb/tb_tinydec.sv
// tb_tinydec: self-checking bench for tinydec. Ciphertext is produced by a
// behavioural tinyenc model, so every decryption must return the original word.
// Build with TINYDEC_CBC_EN defined to exercise the iv chaining path.
module tb_tinydec;

   logic        clk = 1'b0;
   logic        prstb;
   logic        ack;
   logic [31:0] rdata;
   logic [31:0] wdata;
   logic        req;
   logic        pready;
   logic [31:0] prdata;
   logic [31:0] pwdata;
   logic        pwrite;
   logic [31:0] paddr;
   logic        psel;
   logic        penable;

   always #5 clk = ~clk;

   tinydec dut (
      .clk     (clk),
      .prstb   (prstb),
      .ack     (ack),
      .rdata   (rdata),
      .wdata   (wdata),
      .req     (req),
      .pready  (pready),
      .prdata  (prdata),
      .pwdata  (pwdata),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .psel    (psel),
      .penable (penable)
   );

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [63:0] key_m   = 64'h816fc52b09e74da3;
   logic [15:0] delta_m = 16'h9E37;
   logic [31:0] iv_m    = 32'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] mix(input logic [15:0] v, input logic [15:0] s,
                                       input logic [15:0] a, input logic [15:0] b);
      logic [15:0] t;
      t = v << 4;
      return (t + a) ^ (v + s) ^ ((v >> 5) + b);
   endfunction

   // Forward cipher (the tinyenc side of the link).
   function automatic logic [31:0] tea_enc(input logic [31:0] p, input logic [63:0] k,
                                           input logic [15:0] d);
      logic [15:0] x, y, s;
      y = p[31:16];
      x = p[15:0];
      s = 16'h0;
      for (int r = 0; r < 16; r++) begin
         s = s + d;
         x = x + mix(y, s, k[15:0], k[31:16]);
         y = y + mix(x, s, k[47:32], k[63:48]);
      end
      return {y, x};
   endfunction

   task automatic make_ct(input logic [31:0] p, output logic [31:0] c);
`ifdef TINYDEC_CBC_EN
      c    = tea_enc(p ^ iv_m, key_m, delta_m);
      iv_m = c;
`else
      c    = tea_enc(p, key_m, delta_m);
`endif
   endtask

   task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
      paddr = addr; pwdata = data; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
      tick;
      penable = 1'b1;
      tick;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
      paddr = addr; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
      tick;
      penable = 1'b1;
      tick;
      data = prdata;
      psel = 1'b0; penable = 1'b0;
   endtask

   // Accept one word, optionally stall the engine via psel and poke req while busy.
   // lat counts clk edges from the accepting edge to the edge where ack rises.
   task automatic run_word(input logic [31:0] c, input int stall_at, input int stall_len,
                           input int busy_req_at, output logic [31:0] p, output int lat);
      int guard;
      wdata = c;
      req   = 1'b1;
      guard = 0;
      do begin
         tick;
         guard++;
      end while (ack !== 1'b0 && guard < 50);
      req = 1'b0;
      p   = 'x;
      lat = 0;
      if (ack !== 1'b0) begin
         check("accept_timeout", 32'(ack), 32'h0);
         return;
      end
      do begin
         psel    = (stall_len > 0 && lat >= stall_at && lat < stall_at + stall_len);
         paddr   = 32'h10;
         penable = 1'b0;
         pwrite  = 1'b0;
         req     = (lat == busy_req_at);
         tick;
         lat++;
      end while (ack !== 1'b1 && lat < 100);
      psel = 1'b0;
      req  = 1'b0;
      if (ack !== 1'b1) check("done_timeout", 32'(ack), 32'h1);
      p = rdata;
   endtask

   logic [31:0] rd, c, c2, p_out, p1, p2;
   int          lat;
   logic [31:0] vec [3] = '{32'h00000000, 32'h12345678, 32'hFFFFFFFF};

   initial begin
      prstb = 1'b0; req = 1'b0; wdata = '0; pwdata = '0; pwrite = 1'b0;
      paddr = '0; psel = 1'b0; penable = 1'b0;
      repeat (3) tick;
      prstb = 1'b1;
      tick; tick;

      check("rst_ack", 32'(ack), 32'h1);
      check("rst_rdata", rdata, 32'h0);
      apb_read(32'h00, rd); check("rst_key10", rd, 32'h09e74da3);
      apb_read(32'h04, rd); check("rst_key32", rd, 32'h816fc52b);
      apb_read(32'h08, rd); check("rst_delta", rd, 32'h00009E37);
      apb_read(32'h10, rd); check("status_idle", rd, 32'h0);
      apb_read(32'h20, rd); check("unmapped", rd, 32'h0);
      check("pready", 32'(pready), 32'h1);

`ifndef TINYDEC_CBC_EN
      apb_write(32'h0C, 32'h11111111);
      apb_read(32'h0C, rd); check("iv_absent", rd, 32'h0);
`endif

      foreach (vec[n]) begin
         make_ct(vec[n], c);
         run_word(c, 0, 0, -1, p_out, lat);
         check($sformatf("rt%0d_data", n), p_out, vec[n]);
         check($sformatf("rt%0d_lat", n), 32'(lat), 32'd16);
      end

      apb_write(32'h00, 32'hA5A55A5A); key_m[31:0]  = 32'hA5A55A5A;
      apb_write(32'h04, 32'h0F0FF0F0); key_m[63:32] = 32'h0F0FF0F0;
      apb_write(32'h08, 32'h00000001); delta_m      = 16'h0001;
      apb_read(32'h04, rd); check("wr_key32", rd, 32'h0F0FF0F0);
      apb_read(32'h08, rd); check("wr_delta", rd, 32'h00000001);
      make_ct(32'hDEADBEEF, c);
      run_word(c, 0, 0, -1, p_out, lat);
      check("newkey_data", p_out, 32'hDEADBEEF);

      // Stall mid-decryption with psel for 3 clk plus a req poke while busy.
      make_ct(32'hCAFEF00D, c);
      run_word(c, 5, 3, 2, p_out, lat);
      check("stall_data", p_out, 32'hCAFEF00D);
      check("stall_lat", 32'(lat), 32'd19);
      check("status_busy", prdata, 32'h1);
      tick;
      check("busy_req_ignored", 32'(ack), 32'h1);

      // Back-to-back: req held high re-accepts on the cycle ack rises.
      make_ct(32'h0BADC0DE, c);
      make_ct(32'h76543210, c2);
      wdata = c; req = 1'b1;
      lat = 0;
      do begin tick; lat++; end while (ack !== 1'b0 && lat < 50);
      wdata = c2;
      lat = 0;
      do begin tick; lat++; end while (ack !== 1'b1 && lat < 100);
      check("b2b_lat1", 32'(lat), 32'd16);
      check("b2b_data1", rdata, 32'h0BADC0DE);
      tick;
      check("b2b_reaccept", 32'(ack), 32'h0);
      req = 1'b0;
      lat = 1;
      do begin tick; lat++; end while (ack !== 1'b1 && lat < 100);
      check("b2b_lat2", 32'(lat), 32'd17);
      check("b2b_data2", rdata, 32'h76543210);

      // Reset pulsed around round 8.
      make_ct(32'h13579BDF, c);
      wdata = c; req = 1'b1;
      lat = 0;
      do begin tick; lat++; end while (ack !== 1'b0 && lat < 50);
      req = 1'b0;
      repeat (7) tick;
      check("mid_busy", 32'(ack), 32'h0);
      prstb = 1'b0;
      #1;
      check("mid_rst_ack", 32'(ack), 32'h1);
      check("mid_rst_rdata", rdata, 32'h0);
      tick;
      prstb = 1'b1;
      tick; tick;
      key_m = 64'h816fc52b09e74da3; delta_m = 16'h9E37; iv_m = 32'h0;
      apb_read(32'h00, rd); check("mid_rst_key10", rd, 32'h09e74da3);
      apb_read(32'h04, rd); check("mid_rst_key32", rd, 32'h816fc52b);
      apb_read(32'h08, rd); check("mid_rst_delta", rd, 32'h00009E37);
      make_ct(32'h2468ACE0, c);
      run_word(c, 0, 0, -1, p_out, lat);
      check("post_rst_data", p_out, 32'h2468ACE0);

`ifdef TINYDEC_CBC_EN
      apb_write(32'h0C, 32'h11111111); iv_m = 32'h11111111;
      p1 = 32'hA1B2C3D4; p2 = 32'h55AA33CC;
      make_ct(p1, c);
      make_ct(p2, c2);
      run_word(c, 0, 0, -1, p_out, lat);  check("cbc_word1", p_out, p1);
      run_word(c2, 0, 0, -1, p_out, lat); check("cbc_word2", p_out, p2);
      apb_read(32'h0C, rd); check("cbc_iv_chain", rd, c2);
`endif

      for (int n = 0; n < 8; n++) begin
         key_m   = {$urandom, $urandom};
         rd      = $urandom;
         delta_m = rd[15:0];
         apb_write(32'h00, key_m[31:0]);
         apb_write(32'h04, key_m[63:32]);
         apb_write(32'h08, rd);
         p1 = $urandom;
         make_ct(p1, c);
         run_word(c, 0, 0, -1, p_out, lat);
         check($sformatf("rand%0d_data", n), p_out, p1);
         check($sformatf("rand%0d_lat", n), 32'(lat), 32'd16);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
